// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: arbitrates one shared ALU between the execute-stage
// requester (A) and the address/aux requester (B). It owns the carry/zero
// flag registers, evaluates conditional-execution predicates against them,
// and returns a registered result one cycle after each grant.
module alu_share_ctrl #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold,

  input  logic         a_valid,
  output logic         a_ready,
  input  logic [W-1:0] a_in1,
  input  logic [W-1:0] a_in2,
  input  logic         a_op,
  input  logic [1:0]   a_cond,

  input  logic         b_valid,
  output logic         b_ready,
  input  logic [W-1:0] b_in1,
  input  logic [W-1:0] b_in2,
  input  logic         b_op,
  input  logic [1:0]   b_cond,

  output logic [W-1:0] alu_in1,
  output logic [W-1:0] alu_in2,
  output logic         alu_op,
  input  logic [W-1:0] alu_out,
  input  logic         alu_zero,
  input  logic         alu_carry,

  output logic         rsp_valid,
  output logic         rsp_id,
  output logic         rsp_exec,
  output logic [W-1:0] rsp_data,

  output logic         flag_c,
  output logic         flag_z,
  input  logic         flag_ld,
  input  logic         flag_c_in,
  input  logic         flag_z_in
);

  // Predicate encodings; COND_NEVER is the reserved code, which squashes.
  typedef enum logic [1:0] {
    COND_ALWAYS = 2'b00,
    COND_C      = 2'b01,
    COND_Z      = 2'b10,
    COND_NEVER  = 2'b11
  } cond_e;

  localparam logic OP_ADD = 1'b0;

  logic  ptr_b;     // 1: B wins the next contended cycle, 0: A wins
  logic  gnt_a;
  logic  gnt_b;
  logic  gnt;
  cond_e sel_cond;
  logic  pred;
  logic  exec;

  // Grant: round-robin on contention, nothing while stalled or in reset.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!reset && !hold) begin
      if (a_valid && b_valid) begin
        gnt_a = !ptr_b;
        gnt_b = ptr_b;
      end else begin
        gnt_a = a_valid;
        gnt_b = b_valid;
      end
    end
  end

  assign a_ready = gnt_a;
  assign b_ready = gnt_b;
  assign gnt     = gnt_a | gnt_b;

  // Operand mux toward the ALU; drives zeros when nobody is granted.
  always_comb begin
    alu_in1 = '0;
    alu_in2 = '0;
    alu_op  = OP_ADD;
    if (gnt_a) begin
      alu_in1 = a_in1;
      alu_in2 = a_in2;
      alu_op  = a_op;
    end else if (gnt_b) begin
      alu_in1 = b_in1;
      alu_in2 = b_in2;
      alu_op  = b_op;
    end
  end

  // The predicate uses the flags as they stand at the start of the grant
  // cycle, so back-to-back ops observe the previous op's update.
  assign sel_cond = cond_e'(gnt_b ? b_cond : a_cond);

  // Predicate evaluation against the architectural flags.
  always_comb begin
    pred = 1'b0;
    unique case (sel_cond)
      COND_ALWAYS: pred = 1'b1;
      COND_C:      pred = flag_c;
      COND_Z:      pred = flag_z;
      COND_NEVER:  pred = 1'b0;
      default:     pred = 1'b0;
    endcase
  end

  assign exec = gnt & pred;

  // Round-robin pointer: moves away from whoever was just granted.
  // NOTE: sequential state uses nonblocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_b <= 1'b0;
    end else if (gnt_a) begin
      ptr_b <= 1'b1;
    end else if (gnt_b) begin
      ptr_b <= 1'b0;
    end
  end

  // Response register: one-cycle pulse per grant, data zeroed when squashed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_exec  <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= gnt;
      rsp_exec  <= exec;
      rsp_data  <= exec ? alu_out : '0;
      if (gnt) begin
        rsp_id <= gnt_b;
      end
    end
  end

  // Flag registers: an explicit restore overrides any executing op;
  // NAND never touches carry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (flag_ld) begin
      flag_c <= flag_c_in;
      flag_z <= flag_z_in;
    end else if (exec) begin
      flag_z <= alu_zero;
      if (alu_op == OP_ADD) begin
        flag_c <= alu_carry;
      end
    end
  end

  // At most one requester is ever granted in a cycle.
  a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
    !(a_ready && b_ready));

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: behavioural ALU, directed stimulus with
// hand-computed expectations pushed to a scoreboard, and a monitor that
// pops and compares on every response pulse.
module tb_alu_share_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         hold;
  logic         a_valid, a_ready, a_op;
  logic [W-1:0] a_in1, a_in2;
  logic [1:0]   a_cond;
  logic         b_valid, b_ready, b_op;
  logic [W-1:0] b_in1, b_in2;
  logic [1:0]   b_cond;
  logic [W-1:0] alu_in1, alu_in2, alu_out;
  logic         alu_op, alu_zero, alu_carry;
  logic         rsp_valid, rsp_id, rsp_exec;
  logic [W-1:0] rsp_data;
  logic         flag_c, flag_z, flag_ld, flag_c_in, flag_z_in;

  typedef struct packed {
    logic         id;
    logic         exec;
    logic [W-1:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   n_rsp = 0;

  always #5 clk = ~clk;

  // Behavioural ALU: ADD with carry-out, NAND with carry forced to 0.
  logic [W:0] sum;
  assign sum       = {1'b0, alu_in1} + {1'b0, alu_in2};
  assign alu_out   = alu_op ? ~(alu_in1 & alu_in2) : sum[W-1:0];
  assign alu_zero  = (alu_out == '0);
  assign alu_carry = alu_op ? 1'b0 : sum[W];

  alu_share_ctrl #(.W(W)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .a_valid(a_valid), .a_ready(a_ready), .a_in1(a_in1), .a_in2(a_in2),
    .a_op(a_op), .a_cond(a_cond),
    .b_valid(b_valid), .b_ready(b_ready), .b_in1(b_in1), .b_in2(b_in2),
    .b_op(b_op), .b_cond(b_cond),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_exec(rsp_exec),
    .rsp_data(rsp_data),
    .flag_c(flag_c), .flag_z(flag_z), .flag_ld(flag_ld),
    .flag_c_in(flag_c_in), .flag_z_in(flag_z_in)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic id, input logic ex, input logic [W-1:0] d);
    rsp_t e;
    e.id   = id;
    e.exec = ex;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", rsp_valid, 0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        n_rsp++;
        check("rsp_id",   rsp_id,   e.id);
        check("rsp_exec", rsp_exec, e.exec);
        check("rsp_data", rsp_data, e.data);
      end
    end
  end

  // Single-requester transfer, optionally with a coincident flag restore.
  task automatic issue(input string nm, input logic id,
                       input logic [W-1:0] i1, input logic [W-1:0] i2,
                       input logic op, input logic [1:0] cond,
                       input logic x_exec, input logic [W-1:0] x_data,
                       input logic ld, input logic ldc, input logic ldz);
    @(posedge clk); #1;
    if (id) begin
      b_valid = 1'b1; b_in1 = i1; b_in2 = i2; b_op = op; b_cond = cond;
    end else begin
      a_valid = 1'b1; a_in1 = i1; a_in2 = i2; a_op = op; a_cond = cond;
    end
    flag_ld = ld; flag_c_in = ldc; flag_z_in = ldz;
    @(negedge clk);
    check({nm, "_ready"}, id ? b_ready : a_ready, 1);
    push(id, x_exec, x_data);
    @(posedge clk); #1;
    if (id) b_valid = 1'b0;
    else    a_valid = 1'b0;
    flag_ld = 1'b0;
  endtask

  task automatic load_flags(input logic c, input logic z);
    @(posedge clk); #1;
    flag_ld = 1'b1; flag_c_in = c; flag_z_in = z;
    @(posedge clk); #1;
    flag_ld = 1'b0;
    @(negedge clk);
    check("ld_flag_c", flag_c, c);
    check("ld_flag_z", flag_z, z);
  endtask

  task automatic check_flags(input string nm, input logic c, input logic z);
    check({nm, "_c"}, flag_c, c);
    check({nm, "_z"}, flag_z, z);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; hold = 1'b0;
    a_valid = 1'b1; a_in1 = '0; a_in2 = '0; a_op = 1'b0; a_cond = 2'b00;
    b_valid = 1'b0; b_in1 = '0; b_in2 = '0; b_op = 1'b0; b_cond = 2'b00;
    flag_ld = 1'b0; flag_c_in = 1'b0; flag_z_in = 1'b0;

    // Reset state, with A requesting to prove grants are blocked.
    repeat (2) @(negedge clk);
    check("rst_a_ready",   a_ready,   0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id",    rsp_id,    0);
    check("rst_rsp_exec",  rsp_exec,  0);
    check("rst_rsp_data",  rsp_data,  0);
    check_flags("rst", 0, 0);
    @(posedge clk); #1;
    reset = 1'b0; a_valid = 1'b0;

    // Basic ADD and NAND with flag effects.
    issue("add7fff", 0, 16'h7FFF, 16'h0001, 0, 2'b00, 1, 16'h8000, 0, 0, 0);
    @(negedge clk); check_flags("add7fff", 0, 0);
    issue("addffff", 0, 16'hFFFF, 16'h0001, 0, 2'b00, 1, 16'h0000, 0, 0, 0);
    @(negedge clk); check_flags("addffff", 1, 1);
    issue("nand_b", 1, 16'hFFFF, 16'hFFFF, 1, 2'b00, 1, 16'h0000, 0, 0, 0);
    @(negedge clk); check_flags("nand_b", 1, 1);

    // Contention for 4 cycles, pointer at A: grants A, B, A, B.
    @(posedge clk); #1;
    a_valid = 1; a_in1 = 16'h0001; a_in2 = 16'h0002; a_op = 0; a_cond = 2'b00;
    b_valid = 1; b_in1 = 16'h00FF; b_in2 = 16'h0F0F; b_op = 1; b_cond = 2'b00;
    @(negedge clk);
    check("rr0_a", a_ready, 1); check("rr0_b", b_ready, 0);
    push(0, 1, 16'h0003);
    @(posedge clk); #1;
    a_in1 = 16'h8000; a_in2 = 16'h8000;
    @(negedge clk);
    check("rr1_a", a_ready, 0); check("rr1_b", b_ready, 1);
    check("rr1_rsp", rsp_valid, 1);
    push(1, 1, 16'hFFF0);
    @(posedge clk); #1;
    b_in1 = 16'h1234; b_in2 = 16'hFFFF; b_cond = 2'b10;
    @(negedge clk);
    check("rr2_a", a_ready, 1); check("rr2_b", b_ready, 0);
    check("rr2_rsp", rsp_valid, 1);
    push(0, 1, 16'h0000);
    @(posedge clk); #1;
    a_valid = 0;
    @(negedge clk);
    check("rr3_a", a_ready, 0); check("rr3_b", b_ready, 1);
    check("rr3_rsp", rsp_valid, 1);
    push(1, 1, 16'hEDCB);
    @(posedge clk); #1;
    b_valid = 0;
    @(negedge clk);
    check("rr4_rsp", rsp_valid, 1);
    check_flags("rr_end", 1, 0);

    // Predicates: squashed with C=0, executed with C=1, reserved never runs.
    load_flags(0, 0);
    issue("cond_c0", 0, 16'h0003, 16'h0004, 0, 2'b01, 0, 16'h0000, 0, 0, 0);
    @(negedge clk); check_flags("cond_c0", 0, 0);
    load_flags(1, 0);
    issue("cond_c1", 0, 16'h0003, 16'h0004, 0, 2'b01, 1, 16'h0007, 0, 0, 0);
    @(negedge clk); check_flags("cond_c1", 0, 0);
    issue("cond_11", 1, 16'hFFFF, 16'h0001, 0, 2'b11, 0, 16'h0000, 0, 0, 0);
    @(negedge clk); check_flags("cond_11", 0, 0);

    // Flag restore coinciding with a flag-setting grant: restore wins.
    issue("ld_win", 0, 16'hFFFF, 16'h0001, 0, 2'b00, 1, 16'h0000, 1, 0, 0);

    // Stall for 3 cycles with both valid; previous response still lands.
    hold = 1;
    a_valid = 1; a_in1 = 16'h8000; a_in2 = 16'h8001; a_op = 0; a_cond = 2'b00;
    b_valid = 1; b_in1 = 16'hFFFF; b_in2 = 16'h0001; b_op = 0; b_cond = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_a_ready", a_ready, 0);
      check("hold_b_ready", b_ready, 0);
      if (i == 0) begin
        check_flags("ld_win", 0, 0);
        flag_ld = 1; flag_c_in = 1; flag_z_in = 0;
      end else begin
        check("hold_rsp_valid", rsp_valid, 0);
      end
      if (i == 1) begin
        flag_ld = 0;
        check_flags("hold_ld", 1, 0);
      end
    end
    @(posedge clk); #1;
    hold = 0;
    // Last grant before the stall was A, so B wins first.
    @(negedge clk);
    check("unhold_b", b_ready, 1); check("unhold_a", a_ready, 0);
    push(1, 1, 16'h0000);
    @(posedge clk); #1;
    b_valid = 0;
    @(negedge clk);
    check("unhold2_a", a_ready, 1);
    @(posedge clk); #1;
    check("pre_rst_valid", rsp_valid, 1);
    check("pre_rst_id",    rsp_id,    0);
    check("pre_rst_data",  rsp_data,  16'h0001);
    check_flags("pre_rst", 1, 0);

    // Reset right after a grant: response and flags cleared at once.
    reset = 1;
    #1;
    check("midrst_valid", rsp_valid, 0);
    check("midrst_a_ready", a_ready, 0);
    check_flags("midrst", 0, 0);
    @(posedge clk); #1;
    a_in1 = 16'h0010; a_in2 = 16'h0020;
    b_valid = 1; b_in1 = 16'h0000; b_in2 = 16'h0000; b_op = 1; b_cond = 2'b00;
    @(posedge clk); #1;
    reset = 0;
    // Pointer returns to A after reset even though B was favoured before.
    @(negedge clk);
    check("post_rst_a", a_ready, 1); check("post_rst_b", b_ready, 0);
    push(0, 1, 16'h0030);
    @(posedge clk); #1;
    a_valid = 0;
    @(negedge clk);
    check("post_rst_b2", b_ready, 1);
    push(1, 1, 16'hFFFF);
    @(posedge clk); #1;
    b_valid = 0;

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("rsp_count", n_rsp, 14);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
